// File: rtl/output_module.sv
// output_module: NoC router output port with round-robin arbitration, output FIFO and optional stats (OUTPUT_MODULE_STATS_EN)
module output_module #(
  parameter int NUM_INPUTS = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [32*NUM_INPUTS-1:0] req_data,
  input  logic [NUM_INPUTS-1:0]   req_valid,
  output logic [NUM_INPUTS-1:0]   req_ready,
  output logic [31:0]             out_packet,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [15:0]             pkt_count,
  output logic [15:0]             stall_count
);
  localparam int PW = NUM_INPUTS > 1 ? $clog2(NUM_INPUTS) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [PW-1:0] ptr, gidx;
  logic [NUM_INPUTS-1:0] gnt;
  logic [31:0] gdata;
  logic found;
  logic [31:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr, rd;
  logic [AW:0] count;
  logic full, push, pop;
  // round-robin scan starting just after the last winner
  always_comb begin
    gnt = '0;
    gidx = ptr;
    gdata = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_INPUTS; k++) begin
      if (!found && req_valid[(int'(ptr) + k) % NUM_INPUTS]) begin
        found = 1'b1;
        gidx = PW'((int'(ptr) + k) % NUM_INPUTS);
        gnt[(int'(ptr) + k) % NUM_INPUTS] = 1'b1;
        gdata = req_data[((int'(ptr) + k) % NUM_INPUTS) * 32 +: 32];
      end
    end
  end
  assign full = count == (AW+1)'(FIFO_DEPTH);
  assign req_ready = (rst || full) ? '0 : gnt;
  assign push = |req_ready;
  assign out_valid = count != '0;
  assign pop = out_valid && out_ready;
  assign out_packet = mem[rd];
  // arbitration pointer and FIFO bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= PW'(NUM_INPUTS - 1);
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else begin
      if (push) ptr <= gidx;
      if (push) wr <= wr + 1'b1;
      if (pop) rd <= rd + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end
  // FIFO storage, contents are don't-care while empty
  always_ff @(posedge clk) begin
    if (push) mem[wr] <= gdata;
  end
`ifdef OUTPUT_MODULE_STATS_EN
  logic [15:0] pkt_q, stall_q;
  // saturating delivery and stall counters
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_q <= '0;
      stall_q <= '0;
    end else begin
      if (pop && pkt_q != 16'hFFFF) pkt_q <= pkt_q + 16'd1;
      if (out_valid && !out_ready && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
    end
  end
  assign pkt_count = pkt_q;
  assign stall_count = stall_q;
`else
  assign pkt_count = 16'h0000;
  assign stall_count = 16'h0000;
`endif
endmodule
